mb_scan_controller: RTL and testbench

- Macroblock-level scheduler between the syntax decoding front end (mb_type/residual parse) and the reconstruction back end (intra pred + IQIT + sum).
- Walks raster MB addresses from first_mb_in_slice, issues start pulses to parse and recon, and overlaps parse of MB n+1 with recon of MB n through a one-deep handoff slot.
- Flags slice and picture completion.

---
 rtl/mb_scan_controller_pkg.sv | 27 ++
 rtl/mb_scan_controller_if.sv | 48 ++++
 rtl/mb_scan_controller_addr_walker.sv | 81 ++++++++
 rtl/mb_scan_controller.sv | 187 ++++++++++++++++++
 tb/tb_mb_scan_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mb_scan_controller_pkg.sv
// Shared types and defaults for the macroblock scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mb_scan_controller_pkg;

    localparam int MBSC_DIM_W = 8;
    localparam int MBSC_MBN_W = 16;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_INIT = 2'd1,
        P_BUSY = 2'd2,
        P_HOLD = 2'd3
    } p_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } r_state_e;

    // Attributes that travel with an MB from the parse slot into recon.
    typedef struct packed {
        logic eos;       // slice data ended with this MB
        logic last_pic;  // final MB of the picture
    } recon_tag_t;

endpackage

// File: rtl/mb_scan_controller_if.sv
// Signal bundle between the scan controller and the parse/recon engines.
// Latency: n/a (wiring only).
// Backpressure: n/a; engines pace the controller through their done pulses.
// Ports: master = controller side (drives starts, coordinates, status);
//        slave  = environment side (drives SPS, slice and done pulses).
interface mb_scan_controller_if
    import mb_scan_controller_pkg::*;
#(
    parameter int DIM_W = MBSC_DIM_W,
    parameter int MBN_W = MBSC_MBN_W
) ();

    logic             sps_complete;
    logic [DIM_W-1:0] pic_width_in_mbs_minus1;
    logic [DIM_W-1:0] pic_height_in_map_units_minus1;
    logic             slice_start;
    logic [MBN_W-1:0] first_mb_in_slice;
    logic             mb_parse_done;
    logic             last_mb_of_slice;
    logic             mb_recon_done;

    logic             parse_start;
    logic [DIM_W-1:0] mb_x_parse;
    logic [DIM_W-1:0] mb_y_parse;
    logic [MBN_W-1:0] mb_num_parse;
    logic             recon_start;
    logic [DIM_W-1:0] mb_x_recon;
    logic [DIM_W-1:0] mb_y_recon;
    logic             slice_done;
    logic             pic_done;
    logic             slice_error;
    logic             busy;

    modport master (
        input  sps_complete, pic_width_in_mbs_minus1, pic_height_in_map_units_minus1,
               slice_start, first_mb_in_slice, mb_parse_done, last_mb_of_slice, mb_recon_done,
        output parse_start, mb_x_parse, mb_y_parse, mb_num_parse,
               recon_start, mb_x_recon, mb_y_recon, slice_done, pic_done, slice_error, busy
    );

    modport slave (
        output sps_complete, pic_width_in_mbs_minus1, pic_height_in_map_units_minus1,
               slice_start, first_mb_in_slice, mb_parse_done, last_mb_of_slice, mb_recon_done,
        input  parse_start, mb_x_parse, mb_y_parse, mb_num_parse,
               recon_start, mb_x_recon, mb_y_recon, slice_done, pic_done, slice_error, busy
    );

endinterface

// File: rtl/mb_scan_controller_addr_walker.sv
// Raster MB address walker: converts first_mb into x/y and steps along the row.
// Latency: init takes 1 + first_mb/(W+1) steps; advance is single-cycle.
// Backpressure: none; it moves only when the controller asserts a command.
// Ports: clk/reset_n; load_i, init_step_i, advance_i commands; first_mb_i,
//        width_m1_i; init_done_o, x_o, y_o, num_o.
module mb_addr_walker
    import mb_scan_controller_pkg::*;
#(
    parameter int DIM_W = MBSC_DIM_W,
    parameter int MBN_W = MBSC_MBN_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             init_step_i,
    input  logic             advance_i,
    input  logic [MBN_W-1:0] first_mb_i,
    input  logic [DIM_W-1:0] width_m1_i,
    output logic             init_done_o,
    output logic [DIM_W-1:0] x_o,
    output logic [DIM_W-1:0] y_o,
    output logic [MBN_W-1:0] num_o
);

    logic [MBN_W-1:0] rem_q, rem_d;
    logic [MBN_W-1:0] num_q, num_d;
    logic [DIM_W-1:0] x_q, x_d;
    logic [DIM_W-1:0] y_q, y_d;
    logic [MBN_W-1:0] width_ext;

    assign width_ext   = MBN_W'(width_m1_i);
    // Remainder fits in one row: it is the column of first_mb.
    assign init_done_o = (rem_q <= width_ext);

    always_comb begin
        rem_d = rem_q;
        num_d = num_q;
        x_d   = x_q;
        y_d   = y_q;
        if (load_i) begin
            rem_d = first_mb_i;
            y_d   = '0;
            num_d = first_mb_i;
        end else if (init_step_i) begin
            // Division by repeated subtraction, one row per cycle.
            if (!init_done_o) begin
                rem_d = rem_q - (width_ext + MBN_W'(1));
                y_d   = y_q + DIM_W'(1);
            end else begin
                x_d = rem_q[DIM_W-1:0];
            end
        end else if (advance_i) begin
            if (x_q == width_m1_i) begin
                x_d = '0;
                y_d = y_q + DIM_W'(1);
            end else begin
                x_d = x_q + DIM_W'(1);
            end
            num_d = num_q + MBN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q <= '0;
            num_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            rem_q <= rem_d;
            num_q <= num_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign num_o = num_q;

endmodule

// File: rtl/mb_scan_controller.sv
// MB scheduler: walks raster addresses, starts parse and recon, overlaps parse n+1 with recon n.
// Latency: mb_parse_done -> recon_start two cycles later when recon is idle.
// Backpressure: a parsed MB waits in a one-deep slot (P_HOLD) until recon is free.
// Ports: clk, reset_n (async active-low); sif (master modport) carries SPS inputs,
//        slice/done pulses in, and start pulses, coordinates, done/error flags, busy out.
module mb_scan_controller
    import mb_scan_controller_pkg::*;
#(
    parameter int DIM_W = MBSC_DIM_W,
    parameter int MBN_W = MBSC_MBN_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mb_scan_controller_if.master sif
);

    localparam int PS_W = 2 * DIM_W + 1;

    p_state_e         p_state_q, p_state_d;
    r_state_e         r_state_q, r_state_d;
    logic [PS_W-1:0]  pic_size_q, pic_size_d;
    logic             eos_q, eos_d;
    recon_tag_t       tag_q, tag_d;
    logic [DIM_W-1:0] x_recon_q, x_recon_d;
    logic [DIM_W-1:0] y_recon_q, y_recon_d;
    logic             parse_start_q, parse_start_d;
    logic             recon_start_q, recon_start_d;
    logic             slice_done_q, slice_done_d;
    logic             pic_done_q, pic_done_d;
    logic             slice_error_q, slice_error_d;

    logic             wk_load, wk_init, wk_adv, wk_init_done;
    logic [DIM_W-1:0] x_parse, y_parse;
    logic [MBN_W-1:0] num_parse;
    logic             start_ok;
    logic             handoff;
    logic             at_pic_end;

    mb_addr_walker #(
        .DIM_W (DIM_W),
        .MBN_W (MBN_W)
    ) u_walker (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (wk_load),
        .init_step_i (wk_init),
        .advance_i   (wk_adv),
        .first_mb_i  (sif.first_mb_in_slice),
        .width_m1_i  (sif.pic_width_in_mbs_minus1),
        .init_done_o (wk_init_done),
        .x_o         (x_parse),
        .y_o         (y_parse),
        .num_o       (num_parse)
    );

    assign pic_size_d = (PS_W'(sif.pic_width_in_mbs_minus1) + PS_W'(1))
                      * (PS_W'(sif.pic_height_in_map_units_minus1) + PS_W'(1));

    // Compared at 32 bits so pic_size_q == 0 never matches an address.
    assign at_pic_end = (32'(num_parse) == 32'(pic_size_q) - 32'd1);
    assign start_ok   = sif.sps_complete
                     && (32'(sif.first_mb_in_slice) < 32'(pic_size_q))
                     && (r_state_q == R_IDLE);
    // Registered states only: no same-cycle bypass from a done pulse.
    assign handoff    = (p_state_q == P_HOLD) && (r_state_q == R_IDLE);

    always_comb begin
        p_state_d     = p_state_q;
        r_state_d     = r_state_q;
        eos_d         = eos_q;
        tag_d         = tag_q;
        x_recon_d     = x_recon_q;
        y_recon_d     = y_recon_q;
        parse_start_d = 1'b0;
        recon_start_d = 1'b0;
        slice_done_d  = 1'b0;
        pic_done_d    = 1'b0;
        slice_error_d = 1'b0;
        wk_load       = 1'b0;
        wk_init       = 1'b0;
        wk_adv        = 1'b0;

        // Any slice_start that does not launch a slice is flagged and dropped.
        if (sif.slice_start && !((p_state_q == P_IDLE) && start_ok)) begin
            slice_error_d = 1'b1;
        end

        case (p_state_q)
            P_IDLE: begin
                if (sif.slice_start && start_ok) begin
                    wk_load   = 1'b1;
                    p_state_d = P_INIT;
                end
            end
            P_INIT: begin
                wk_init = 1'b1;
                if (wk_init_done) begin
                    parse_start_d = 1'b1;
                    p_state_d     = P_BUSY;
                end
            end
            P_BUSY: begin
                if (sif.mb_parse_done) begin
                    eos_d     = sif.last_mb_of_slice;
                    p_state_d = P_HOLD;
                end
            end
            P_HOLD: begin
                if (handoff) begin
                    x_recon_d      = x_parse;
                    y_recon_d      = y_parse;
                    recon_start_d  = 1'b1;
                    tag_d.eos      = eos_q;
                    tag_d.last_pic = at_pic_end;
                    // The picture's final MB ends the slice regardless of eos.
                    if (!eos_q && !at_pic_end) begin
                        wk_adv        = 1'b1;
                        parse_start_d = 1'b1;
                        p_state_d     = P_BUSY;
                    end else begin
                        p_state_d = P_IDLE;
                    end
                end
            end
            default: p_state_d = P_IDLE;
        endcase

        case (r_state_q)
            R_IDLE: begin
                if (handoff) begin
                    r_state_d = R_BUSY;
                end
            end
            R_BUSY: begin
                if (sif.mb_recon_done) begin
                    r_state_d    = R_IDLE;
                    slice_done_d = tag_q.eos || tag_q.last_pic;
                    pic_done_d   = tag_q.last_pic;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_state_q     <= P_IDLE;
            r_state_q     <= R_IDLE;
            pic_size_q    <= '0;
            eos_q         <= 1'b0;
            tag_q         <= '0;
            x_recon_q     <= '0;
            y_recon_q     <= '0;
            parse_start_q <= 1'b0;
            recon_start_q <= 1'b0;
            slice_done_q  <= 1'b0;
            pic_done_q    <= 1'b0;
            slice_error_q <= 1'b0;
        end else begin
            p_state_q     <= p_state_d;
            r_state_q     <= r_state_d;
            pic_size_q    <= pic_size_d;
            eos_q         <= eos_d;
            tag_q         <= tag_d;
            x_recon_q     <= x_recon_d;
            y_recon_q     <= y_recon_d;
            parse_start_q <= parse_start_d;
            recon_start_q <= recon_start_d;
            slice_done_q  <= slice_done_d;
            pic_done_q    <= pic_done_d;
            slice_error_q <= slice_error_d;
        end
    end

    assign sif.parse_start  = parse_start_q;
    assign sif.mb_x_parse   = x_parse;
    assign sif.mb_y_parse   = y_parse;
    assign sif.mb_num_parse = num_parse;
    assign sif.recon_start  = recon_start_q;
    assign sif.mb_x_recon   = x_recon_q;
    assign sif.mb_y_recon   = y_recon_q;
    assign sif.slice_done   = slice_done_q;
    assign sif.pic_done     = pic_done_q;
    assign sif.slice_error  = slice_error_q;
    assign sif.busy         = (p_state_q != P_IDLE) || (r_state_q != R_IDLE);

endmodule

// File: tb/tb_mb_scan_controller.sv
// Scoreboard bench for mb_scan_controller: reference model predicts MB order and timing.
// Latency: n/a.
// Backpressure: the bench's parse/recon engine model paces the DUT with done pulses.
module tb_mb_scan_controller;

    localparam int DIM_W = 8;
    localparam int MBN_W = 16;

    typedef struct { int x; int y; int num; int first_cyc; } pexp_t;
    typedef struct { int x; int y; } rexp_t;
    typedef struct { bit pic; int n; } eexp_t;

    logic clk;
    logic reset_n;

    mb_scan_controller_if #(.DIM_W(DIM_W), .MBN_W(MBN_W)) sif ();

    mb_scan_controller #(.DIM_W(DIM_W), .MBN_W(MBN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sif     (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard queues, filled at stimulus time.
    pexp_t pq[$];
    rexp_t rq[$];
    eexp_t eq[$];
    int    errq[$];

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 0;
    int  pd_cyc = -100;
    int  rd_cyc = -100;
    bit  rpend = 0;
    int  rcount = 0;

    // Engine model configuration and bookkeeping.
    int  r_dp = 3, r_dr = 5, r_eos = 999;
    int  ps_total = 0, ps_base = 0;
    int  stray_req = 0, stray_ack = 0;
    int  cur_w = 0, cur_h = 0;
    bit  cur_sps = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int outs_nonzero();
        return int'(sif.parse_start | sif.recon_start | sif.slice_done | sif.pic_done
                  | sif.slice_error | sif.busy | (|sif.mb_x_parse) | (|sif.mb_y_parse)
                  | (|sif.mb_num_parse) | (|sif.mb_x_recon) | (|sif.mb_y_recon));
    endfunction

    // Parse/recon engine model: done pulses a fixed number of cycles after each start.
    initial begin
        int pcnt;
        int rcnt;
        bit plast;
        pcnt = 0;
        rcnt = 0;
        plast = 0;
        sif.mb_parse_done = 0;
        sif.mb_recon_done = 0;
        sif.last_mb_of_slice = 0;
        forever begin
            @(posedge clk);
            #1;
            sif.mb_parse_done = 0;
            sif.mb_recon_done = 0;
            sif.last_mb_of_slice = 1'($urandom);
            if (!reset_n) begin
                pcnt = 0;
                rcnt = 0;
            end else begin
                if (pcnt > 0) begin
                    pcnt--;
                    if (pcnt == 0) begin
                        sif.mb_parse_done = 1;
                        sif.last_mb_of_slice = plast;
                    end
                end
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) sif.mb_recon_done = 1;
                end
                if (sif.parse_start) begin
                    pcnt = r_dp;
                    plast = ((ps_total - ps_base) == r_eos);
                    ps_total++;
                end
                if (sif.recon_start) rcnt = r_dr;
                if (stray_req != stray_ack && pcnt == 0 && rcnt == 0) begin
                    stray_ack = stray_req;
                    sif.mb_parse_done = 1;
                    sif.mb_recon_done = 1;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        pexp_t pe;
        rexp_t re;
        eexp_t ee;
        int    ex;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sif.parse_start) begin
                    if (pq.size() == 0) chk("parse_start_unexpected", 1, 0);
                    else begin
                        pe = pq.pop_front();
                        chk("parse_x", sif.mb_x_parse, pe.x);
                        chk("parse_y", sif.mb_y_parse, pe.y);
                        chk("parse_num", sif.mb_num_parse, pe.num);
                        ex = (pe.first_cyc >= 0) ? pe.first_cyc
                           : (rpend ? -1 : imax(pd_cyc, rd_cyc) + 2);
                        chk("parse_start_cycle", cyc, ex);
                    end
                end
                if (sif.recon_start) begin
                    if (rq.size() == 0) chk("recon_start_unexpected", 1, 0);
                    else begin
                        re = rq.pop_front();
                        chk("recon_x", sif.mb_x_recon, re.x);
                        chk("recon_y", sif.mb_y_recon, re.y);
                        chk("recon_start_cycle", cyc, rpend ? -1 : imax(pd_cyc, rd_cyc) + 2);
                    end
                    rpend = 1;
                    rcount++;
                end
                if (sif.slice_done || sif.pic_done) begin
                    if (eq.size() == 0) chk("slice_done_unexpected", 1, 0);
                    else begin
                        ee = eq.pop_front();
                        chk("slice_done", sif.slice_done, 1);
                        chk("pic_done", sif.pic_done, int'(ee.pic));
                        chk("slice_done_cycle", cyc, rd_cyc + 1);
                        chk("recons_in_slice", rcount, ee.n);
                        chk("busy_after_slice", sif.busy, 0);
                    end
                    rcount = 0;
                end
                if (sif.slice_error) begin
                    if (errq.size() == 0) chk("slice_error_unexpected", 1, 0);
                    else chk("slice_error_cycle", cyc, errq.pop_front());
                end
                if (sif.mb_parse_done) pd_cyc = cyc;
                if (sif.mb_recon_done && rpend) begin
                    rd_cyc = cyc;
                    rpend = 0;
                end
            end
        end
    end

    task automatic set_sps(input int w, input int h, input bit ok);
        @(posedge clk);
        #1;
        cur_w = w;
        cur_h = h;
        cur_sps = ok;
        sif.sps_complete = ok;
        sif.pic_width_in_mbs_minus1 = DIM_W'(w);
        sif.pic_height_in_map_units_minus1 = DIM_W'(h);
        repeat (2) @(posedge clk);
    endtask

    task automatic start_slice(input int first, input int eos_at, input int dp, input int dr);
        int pic, n, s, a, w1;
        pexp_t pe;
        rexp_t re;
        eexp_t ee;
        @(posedge clk);
        #1;
        s = cyc;
        w1 = cur_w + 1;
        pic = w1 * (cur_h + 1);
        r_dp = dp;
        r_dr = dr;
        r_eos = eos_at;
        ps_base = ps_total;
        sif.slice_start = 1;
        sif.first_mb_in_slice = MBN_W'(first);
        if (!cur_sps || first >= pic) begin
            errq.push_back(s + 1);
        end else begin
            n = pic - first;
            if (eos_at + 1 < n) n = eos_at + 1;
            for (int k = 0; k < n; k++) begin
                a = first + k;
                pe.x = a % w1;
                pe.y = a / w1;
                pe.num = a;
                // One P_INIT cycle per full row skipped, plus the final one.
                pe.first_cyc = (k == 0) ? s + 2 + first / w1 : -1;
                pq.push_back(pe);
                re.x = pe.x;
                re.y = pe.y;
                rq.push_back(re);
            end
            ee.pic = ((first + n) == pic);
            ee.n = n;
            eq.push_back(ee);
        end
        @(posedge clk);
        #1;
        sif.slice_start = 0;
        sif.first_mb_in_slice = MBN_W'($urandom);
    endtask

    task automatic flush_model();
        pq.delete();
        rq.delete();
        eq.delete();
        errq.delete();
        rpend = 0;
        rcount = 0;
    endtask

    task automatic wait_done(input bit stray);
        int budget, st_at;
        bit done;
        budget = 0;
        done = 0;
        st_at = $urandom_range(2, 15);
        while (!done && budget < 3000) begin
            @(posedge clk);
            #1;
            budget++;
            if (stray && budget == st_at && sif.busy) begin
                sif.slice_start = 1;
                sif.first_mb_in_slice = MBN_W'($urandom_range(0, 3));
                errq.push_back(cyc + 1);
            end else begin
                sif.slice_start = 0;
            end
            done = !sif.busy && !sif.slice_start && pq.size() == 0 && rq.size() == 0
                && eq.size() == 0 && errq.size() == 0;
        end
        chk("slice_completes", int'(done), 1);
        if (!done) flush_model();
    endtask

    task automatic run(input int first, input int eos_at, input int dp, input int dr, input bit stray);
        start_slice(first, eos_at, dp, dr);
        wait_done(stray);
        // Done pulses while idle must produce nothing.
        stray_req++;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int w, h, pic, first, eos, dp, dr;
        bit got;
        reset_n = 1;
        sif.sps_complete = 0;
        sif.pic_width_in_mbs_minus1 = 0;
        sif.pic_height_in_map_units_minus1 = 0;
        sif.slice_start = 0;
        sif.first_mb_in_slice = 0;
        #2 reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", outs_nonzero(), 0);
        reset_n = 1;
        mon_en = 1;

        set_sps(1, 1, 1);
        run(0, 999, 3, 5, 0);        // 2x2 full picture
        set_sps(10, 3, 1);
        run(25, 999, 2, 3, 0);       // multi-row init: x=3, y=2
        set_sps(1, 1, 1);
        run(0, 999, 3, 20, 0);       // slow recon holds parse
        run(0, 1, 3, 5, 0);          // early end of slice
        run(4, 999, 3, 5, 0);        // first_mb out of range
        set_sps(1, 1, 0);
        run(0, 999, 3, 5, 0);        // SPS not ready
        set_sps(2, 2, 1);
        run(1, 999, 2, 6, 1);        // slice_start while busy

        // Reset while recon is in progress.
        set_sps(1, 1, 1);
        start_slice(0, 999, 3, 8);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            got = sif.recon_start;
        end
        chk("recon_before_reset", int'(got), 1);
        @(posedge clk);
        #2;
        mon_en = 0;
        reset_n = 0;
        #1;
        chk("midrun_reset_outputs_zero", outs_nonzero(), 0);
        flush_model();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        mon_en = 1;
        repeat (2) @(posedge clk);
        run(2, 999, 2, 4, 0);

        for (int i = 0; i < 30; i++) begin
            w = $urandom_range(0, 5);
            h = $urandom_range(0, 4);
            pic = (w + 1) * (h + 1);
            set_sps(w, h, $urandom_range(0, 9) != 0);
            first = ($urandom_range(0, 9) == 0) ? pic + $urandom_range(0, 3)
                                                : $urandom_range(0, pic - 1);
            eos = ($urandom_range(0, 2) == 0) ? 999 : $urandom_range(0, pic);
            dp = $urandom_range(1, 4);
            dr = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 20) : $urandom_range(1, 6);
            run(first, eos, dp, dr, $urandom_range(0, 3) == 0);
        end

        chk("leftover_expected_events", pq.size() + rq.size() + eq.size() + errq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
